ball_engine: RTL and testbench

- Parametrised pong ball engine for the 480x272 LCD playfield.
- Owns ball position, direction, per-axis speed, paddle/wall collisions, scoring and serve sequencing; produces the ball pixel for the pixel mux.
- Paddle positions come from the paddle blocks; scores feed the score overlay.

---
 rtl/ball_engine.sv | 206 ++++++++++++++++++++
 tb/tb_ball_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Pong ball engine: motion tick divider, ball position/direction/speed, wall and
// paddle collisions, scoring and serve sequencing, plus the ball pixel output.
//
// state  | meaning
// IDLE   | ball centred and visible, waiting for a serve on a tick
// PLAY   | ball moving one step per tick, collisions active
// SCORED | ball hidden, counting SERVE_DELAY ticks before re-centring
// OVER   | a player reached WIN_SCORE, scores held until a serve clears them
module ball_engine #(
    parameter int H_RES       = 480,
    parameter int V_RES       = 272,
    parameter int SIZE        = 5,
    parameter int L_EDGE      = 5,
    parameter int R_EDGE      = 475,
    parameter int TICK_DIV    = 262144,
    parameter int SPEED_MAX   = 4,
    parameter int SERVE_DELAY = 64,
    parameter int WIN_SCORE   = 9
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [8:0] i_col,
    input  logic [8:0] i_row,
    input  logic [8:0] i_y1,
    input  logic [6:0] i_h1,
    input  logic [8:0] i_y2,
    input  logic [6:0] i_h2,
    input  logic       i_serve,
    output logic       o_color,
    output logic [8:0] o_x,
    output logic [8:0] o_y,
    output logic [3:0] o_score1,
    output logic [3:0] o_score2,
    output logic       o_hit,
    output logic [1:0] o_state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(SERVE_DELAY + 1);
    localparam int VW = $clog2(SPEED_MAX + 1);

    localparam logic [8:0]    X_MID   = 9'((H_RES - SIZE) / 2);
    localparam logic [8:0]    Y_MID   = 9'((V_RES - SIZE) / 2);
    localparam logic [9:0]    Y_MAX   = 10'(V_RES - SIZE);
    localparam logic [9:0]    FACE_R  = 10'(R_EDGE - SIZE);
    localparam logic [9:0]    FACE_L  = 10'(L_EDGE);
    localparam logic [9:0]    X_LIM   = 10'(H_RES);
    localparam logic [9:0]    SZ      = 10'(SIZE);
    localparam logic [VW-1:0] VX_MAX  = VW'(SPEED_MAX);
    localparam logic [VW-1:0] VX_ONE  = VW'(1);
    localparam logic [3:0]    WIN     = 4'(WIN_SCORE);
    localparam logic [TW-1:0] TICK_TC = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DLY_TC  = DW'(SERVE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t        state, nxt_state;
    logic [8:0]    x, nxt_x, y, nxt_y;
    logic [VW-1:0] vx, nxt_vx;
    logic          dir_x, nxt_dir_x, dir_y, nxt_dir_y;
    logic [3:0]    score1, nxt_score1, score2, nxt_score2;
    logic [DW-1:0] delay_cnt, nxt_delay_cnt;
    logic          hit, nxt_hit;
    logic [TW-1:0] tick_cnt;
    logic          tick;

    logic [9:0] x10, y10, vx10;
    logic       ov1, ov2;

    assign tick = (tick_cnt == TICK_TC);
    assign x10  = {1'b0, x};
    assign y10  = {1'b0, y};
    assign vx10 = 10'(vx);
    assign ov1  = (y10 + SZ > {1'b0, i_y1}) && (y10 < {1'b0, i_y1} + {3'b0, i_h1});
    assign ov2  = (y10 + SZ > {1'b0, i_y2}) && (y10 < {1'b0, i_y2} + {3'b0, i_h2});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt  <= '0;
            state     <= IDLE;
            x         <= X_MID;
            y         <= Y_MID;
            vx        <= VX_ONE;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            score1    <= '0;
            score2    <= '0;
            delay_cnt <= '0;
            hit       <= 1'b0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            state     <= nxt_state;
            x         <= nxt_x;
            y         <= nxt_y;
            vx        <= nxt_vx;
            dir_x     <= nxt_dir_x;
            dir_y     <= nxt_dir_y;
            score1    <= nxt_score1;
            score2    <= nxt_score2;
            delay_cnt <= nxt_delay_cnt;
            hit       <= nxt_hit;
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_x         = x;
        nxt_y         = y;
        nxt_vx        = vx;
        nxt_dir_x     = dir_x;
        nxt_dir_y     = dir_y;
        nxt_score1    = score1;
        nxt_score2    = score2;
        nxt_delay_cnt = delay_cnt;
        nxt_hit       = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    nxt_x = X_MID;
                    nxt_y = Y_MID;
                    if (i_serve) begin
                        nxt_state = PLAY;
                        nxt_vx    = VX_ONE;
                        nxt_dir_y = 1'b1;
                    end
                end
                PLAY: begin
                    // vertical and horizontal events are independent within one tick
                    if (!dir_y) begin
                        if (y == 9'd0) nxt_dir_y = 1'b1;
                        else           nxt_y = y - 9'd1;
                    end else if (y10 + 10'd1 > Y_MAX) begin
                        nxt_y     = Y_MAX[8:0];
                        nxt_dir_y = 1'b0;
                    end else begin
                        nxt_y = y + 9'd1;
                    end
                    if (dir_x) begin
                        if ((x10 + vx10 >= FACE_R) && (x10 <= FACE_R) && ov2) begin
                            nxt_x     = FACE_R[8:0];
                            nxt_dir_x = 1'b0;
                            nxt_vx    = (vx < VX_MAX) ? vx + 1'b1 : VX_MAX;
                            nxt_hit   = 1'b1;
                        end else if (x10 + SZ + vx10 > X_LIM) begin
                            nxt_score1 = (score1 == WIN) ? score1 : score1 + 4'd1;
                            nxt_state  = SCORED;
                            nxt_dir_x  = 1'b1;
                        end else begin
                            nxt_x = 9'(x10 + vx10);
                        end
                    end else begin
                        if ((x10 <= FACE_L + vx10) && (x10 >= FACE_L) && ov1) begin
                            nxt_x     = FACE_L[8:0];
                            nxt_dir_x = 1'b1;
                            nxt_vx    = (vx < VX_MAX) ? vx + 1'b1 : VX_MAX;
                            nxt_hit   = 1'b1;
                        end else if (x10 < vx10) begin
                            nxt_score2 = (score2 == WIN) ? score2 : score2 + 4'd1;
                            nxt_state  = SCORED;
                            nxt_dir_x  = 1'b0;
                        end else begin
                            nxt_x = 9'(x10 - vx10);
                        end
                    end
                end
                SCORED: begin
                    if (delay_cnt == DLY_TC) begin
                        nxt_delay_cnt = '0;
                        nxt_x         = X_MID;
                        nxt_y         = Y_MID;
                        nxt_vx        = VX_ONE;
                        nxt_state     = (score1 == WIN || score2 == WIN) ? OVER : IDLE;
                    end else begin
                        nxt_delay_cnt = delay_cnt + 1'b1;
                    end
                end
                OVER: begin
                    nxt_x = X_MID;
                    nxt_y = Y_MID;
                    if (i_serve) begin
                        nxt_score1 = '0;
                        nxt_score2 = '0;
                        nxt_state  = IDLE;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    assign o_color = ((state == IDLE) || (state == PLAY)) &&
                     ({1'b0, i_col} >= x10) && ({1'b0, i_col} < x10 + SZ) &&
                     ({1'b0, i_row} >= y10) && ({1'b0, i_row} < y10 + SZ);
    assign o_x      = x;
    assign o_y      = y;
    assign o_score1 = score1;
    assign o_score2 = score2;
    assign o_hit    = hit;
    assign o_state  = state;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with a 4-clock motion tick: rallies, walls,
// paddle hits, misses, game over and mid-play reset against hand-derived values.
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] col = '0, row = '0;
    logic [8:0] y1 = '0, y2 = '0;
    logic [6:0] h1 = '0, h2 = '0;
    logic       serve = 1'b0;
    logic       color, hit;
    logic [8:0] x, y;
    logic [3:0] score1, score2;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    ball_engine #(.TICK_DIV(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_col(col), .i_row(row),
        .i_y1(y1), .i_h1(h1), .i_y2(y2), .i_h2(h2), .i_serve(serve),
        .o_color(color), .o_x(x), .o_y(y), .o_score1(score1), .o_score2(score2),
        .o_hit(hit), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // one motion tick = 4 clocks; sample 1 ns after the tick edge
    task automatic step(input int n);
        repeat (4 * n) @(posedge clk);
        #1;
    endtask

    task automatic do_serve();
        serve = 1'b1;
        step(1);
        serve = 1'b0;
    endtask

    task automatic pix(input string tag, input int c, input int r, input logic exp_v);
        col = 9'(c);
        row = 9'(r);
        #1;
        chk(tag, 32'(color), 32'(exp_v));
    endtask

    // check the hit pulse drops after one clock, then realign to the next tick
    task automatic hit_drop(input string tag);
        @(posedge clk);
        #1;
        chk(tag, 32'(hit), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst_x", 32'(x), 237);
        chk("rst_y", 32'(y), 133);
        chk("rst_state", 32'(state), 0);
        chk("rst_s1", 32'(score1), 0);
        chk("rst_s2", 32'(score2), 0);
        chk("rst_hit", 32'(hit), 0);
        pix("pix_in_tl", 237, 133, 1'b1);
        pix("pix_out_r", 242, 133, 1'b0);
        pix("pix_in_br", 241, 137, 1'b1);
        pix("pix_out_b", 237, 138, 1'b0);

        // rally to the right paddle, bottom wall on the way
        y2 = 9'd160; h2 = 7'd50; y1 = 9'd40; h1 = 7'd40;
        do_serve();
        chk("srv_state", 32'(state), 1);
        chk("srv_x", 32'(x), 237);
        step(1);
        chk("k1_x", 32'(x), 238);
        chk("k1_y", 32'(y), 134);
        step(133);
        chk("k134_y", 32'(y), 267);
        chk("k134_x", 32'(x), 371);
        step(1);
        chk("k135_y", 32'(y), 267);
        step(1);
        chk("k136_y", 32'(y), 266);
        chk("k136_x", 32'(x), 373);
        step(96);
        chk("k232_x", 32'(x), 469);
        chk("k232_y", 32'(y), 170);
        chk("k232_hit", 32'(hit), 0);
        step(1);
        chk("rhit_pulse", 32'(hit), 1);
        chk("rhit_x", 32'(x), 470);
        chk("rhit_y", 32'(y), 169);
        hit_drop("rhit_clear");
        chk("m1_x", 32'(x), 468);
        chk("m1_y", 32'(y), 168);

        // leftward at vx=2, top wall, then left paddle hit
        y2 = 9'd0; h2 = 7'd10;
        step(167);
        chk("m168_y", 32'(y), 1);
        chk("m168_x", 32'(x), 134);
        step(1);
        chk("m169_y", 32'(y), 0);
        step(1);
        chk("m170_y", 32'(y), 0);
        step(1);
        chk("m171_y", 32'(y), 1);
        chk("m171_x", 32'(x), 128);
        step(61);
        chk("m232_x", 32'(x), 6);
        chk("m232_y", 32'(y), 62);
        step(1);
        chk("lhit_pulse", 32'(hit), 1);
        chk("lhit_x", 32'(x), 5);
        chk("lhit_y", 32'(y), 63);
        hit_drop("lhit_clear");
        chk("n1_x", 32'(x), 8);

        // vx=3 to the right, paddle out of range: passes the face, then misses
        step(153);
        chk("n154_x", 32'(x), 467);
        step(1);
        chk("n155_x", 32'(x), 470);
        chk("n155_hit", 32'(hit), 0);
        chk("n155_state", 32'(state), 1);
        step(1);
        chk("n156_x", 32'(x), 473);
        step(1);
        chk("miss_state", 32'(state), 2);
        chk("miss_s1", 32'(score1), 1);
        chk("miss_s2", 32'(score2), 0);
        pix("miss_pix", 473, 220, 1'b0);
        step(63);
        chk("dly63_state", 32'(state), 2);
        step(1);
        chk("dly64_state", 32'(state), 0);
        chk("dly64_x", 32'(x), 237);
        chk("dly64_y", 32'(y), 133);
        pix("idle_pix", 237, 133, 1'b1);

        // left player scores up to WIN_SCORE
        y2 = 9'd0; h2 = 7'd0;
        for (int p = 2; p <= 9; p++) begin
            do_serve();
            step(238);
            chk("pt_x475", 32'(x), 475);
            chk("pt_play", 32'(state), 1);
            step(1);
            chk("pt_scored", 32'(state), 2);
            chk("pt_s1", 32'(score1), 32'(p));
            step(64);
            chk("pt_after", 32'(state), (p == 9) ? 3 : 0);
        end
        chk("over_x", 32'(x), 237);
        chk("over_y", 32'(y), 133);
        chk("over_s2", 32'(score2), 0);
        pix("over_pix", 237, 133, 1'b0);
        step(3);
        chk("over_hold", 32'(state), 3);
        chk("over_s1", 32'(score1), 9);
        do_serve();
        chk("restart_state", 32'(state), 0);
        chk("restart_s1", 32'(score1), 0);
        chk("restart_s2", 32'(score2), 0);
        pix("restart_pix", 237, 133, 1'b1);

        // right player scores past column 0, next serve goes left
        y2 = 9'd160; h2 = 7'd50; y1 = 9'd0; h1 = 7'd0;
        do_serve();
        step(233);
        chk("e_hit", 32'(hit), 1);
        chk("e_hit_x", 32'(x), 470);
        hit_drop("e_hit_clear");
        step(234);
        chk("e_m235_x", 32'(x), 0);
        chk("e_m235_state", 32'(state), 1);
        step(1);
        chk("e_miss_state", 32'(state), 2);
        chk("e_miss_s2", 32'(score2), 1);
        chk("e_miss_s1", 32'(score1), 0);
        step(64);
        chk("e_idle", 32'(state), 0);
        do_serve();
        step(5);
        chk("e_serve_left_x", 32'(x), 232);

        // reset right after a hit (vx=2), between ticks
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_serve();
        step(233);
        chk("f_hit", 32'(hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_rst_hit", 32'(hit), 0);
        chk("f_rst_x", 32'(x), 237);
        chk("f_rst_y", 32'(y), 133);
        chk("f_rst_state", 32'(state), 0);
        chk("f_rst_s1", 32'(score1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_serve();
        step(1);
        chk("f_vx1_x", 32'(x), 238);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
